// File: rtl/rf_wport_arb_if.sv
// Register-file write-port bundle between two write requesters and the
// arbiter that serializes them onto a single register-file write port.
//   a_* / b_* : valid/ready handshake plus destination index and data
//   we/wR/wD  : registered register-file write port
//   busy      : either holding buffer is occupied
interface rf_wport_arb_if;
  logic        a_valid, a_ready;
  logic [4:0]  a_wr;
  logic [31:0] a_wd;
  logic        b_valid, b_ready;
  logic [4:0]  b_wr;
  logic [31:0] b_wd;
  logic        we;
  logic [4:0]  wR;
  logic [31:0] wD;
  logic        busy;

  // requester side
  modport master (
    output a_valid, a_wr, a_wd, b_valid, b_wr, b_wd,
    input  a_ready, b_ready, we, wR, wD, busy
  );

  // arbiter side
  modport slave (
    input  a_valid, a_wr, a_wd, b_valid, b_wr, b_wd,
    output a_ready, b_ready, we, wR, wD, busy
  );
endinterface

// File: rtl/rf_wport_arb.sv
// Two-requester register-file write-port arbiter.
// Each requester owns a one-entry holding buffer; full buffers are drained
// one per cycle onto the registered write port (we/wR/wD), round-robin when
// FAIR=1, fixed priority to A when FAIR=0. Writes to x0 are accepted and
// silently dropped.
// Ports: clk, rst (async, active-high), wp (rf_wport_arb_if.slave).

// Per-requester holding buffer. ready depends only on registered state and
// the grant, never on valid, so requesters see no combinational loop.
module rf_wport_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [4:0]  wr,
  input  logic [31:0] wd,
  input  logic        gnt,
  output logic        ready,
  output logic        full,
  output logic [4:0]  idx,
  output logic [31:0] dat
);
  logic xfer;

  // A granted buffer drains this edge, so it can take a new entry now.
  assign ready = !full || gnt;
  assign xfer  = valid && ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      idx  <= '0;
      dat  <= '0;
    end else if (xfer && (wr != 5'd0)) begin
      // refill wins over the drain of the same cycle
      full <= 1'b1;
      idx  <= wr;
      dat  <= wd;
    end else if (gnt) begin
      full <= 1'b0;
    end
  end
endmodule

module rf_wport_arb #(
  parameter bit FAIR = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  rf_wport_arb_if.slave  wp
);
  localparam int NUM_LANES = 2;  // lane 0 = A, lane 1 = B

  logic [NUM_LANES-1:0]       vld, rdy, full, gnt;
  logic [NUM_LANES-1:0][4:0]  wr, idx;
  logic [NUM_LANES-1:0][31:0] wd, dat;
  logic                       pri_a;  // A wins the next contention
  logic                       we_q;
  logic [4:0]                 wr_q;
  logic [31:0]                wd_q;

  assign vld = {wp.b_valid, wp.a_valid};
  assign wr  = {wp.b_wr,    wp.a_wr};
  assign wd  = {wp.b_wd,    wp.a_wd};

  assign wp.a_ready = rdy[0];
  assign wp.b_ready = rdy[1];
  assign wp.busy    = |full;
  assign wp.we      = we_q;
  assign wp.wR      = wr_q;
  assign wp.wD      = wd_q;

  // At most one grant; lone full buffer always wins.
  always_comb begin
    gnt = '0;
    if (full[0] && (!full[1] || !FAIR || pri_a)) gnt[0] = 1'b1;
    else if (full[1])                            gnt[1] = 1'b1;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    rf_wport_buf u_buf (
      .clk   (clk),
      .rst   (rst),
      .valid (vld[i]),
      .wr    (wr[i]),
      .wd    (wd[i]),
      .gnt   (gnt[i]),
      .ready (rdy[i]),
      .full  (full[i]),
      .idx   (idx[i]),
      .dat   (dat[i])
    );
  end

  // Registered write port; wR/wD hold their last value while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q  <= 1'b0;
      wr_q  <= '0;
      wd_q  <= '0;
      pri_a <= 1'b1;
    end else begin
      we_q <= |gnt;
      if (|gnt) begin
        wr_q  <= gnt[0] ? idx[0] : idx[1];
        wd_q  <= gnt[0] ? dat[0] : dat[1];
        // the side not granted now gets priority next time
        pri_a <= gnt[1];
      end
    end
  end
endmodule

// File: doc/rf_wport_arb.md
RF_WPORT_ARB -- requirements
Module: rf_wport_arb

Interface
REQ-001 SHALL have parameter FAIR, default 1: 1 = round-robin arbitration, 0 = fixed priority to requester A.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port a_valid  input  1  requester A offers a write.
REQ-005 SHALL have port a_ready  output  1  requester A may transfer this cycle.
REQ-006 SHALL have port a_wr  input  5  requester A destination register index.
REQ-007 SHALL have port a_wd  input  32  requester A write data.
REQ-008 SHALL have ports b_valid, b_ready, b_wr, b_wd with widths and meanings identical to the A ports, for requester B.
REQ-009 SHALL have port we  output  1  register-file write enable.
REQ-010 SHALL have port wR  output  5  register-file write index.
REQ-011 SHALL have port wD  output  32  register-file write data.
REQ-012 SHALL have port busy  output  1  high while either holding buffer is full.

Function
REQ-013 SHALL hold one holding buffer per requester, each with a full flag, index and data.
REQ-014 SHALL define a transfer on requester X as X_valid and X_ready high at the same rising edge.
REQ-015 SHALL drive X_ready = (not full_X) or grant_X, derived from registered state only, never from X_valid.
REQ-016 SHALL load X_wr/X_wd into buffer X and set full_X on a transfer with X_wr != 0.
REQ-017 SHALL complete a transfer with X_wr == 0 without filling the buffer, so no write to x0 ever reaches we.
REQ-018 SHALL compute grants combinationally each cycle from full_A, full_B and the round-robin pointer: at most one grant per cycle.
REQ-019 SHALL, when exactly one buffer is full, grant that buffer.
REQ-020 SHALL, when both buffers are full and FAIR=1, grant the requester not granted most recently, then record the winner in the pointer.
REQ-021 SHALL, when both buffers are full and FAIR=0, always grant A.
REQ-022 SHALL, on a grant, register we=1, wR and wD from the granted buffer at the next edge, giving a latency of 1 cycle from buffer-full to we.
REQ-023 SHALL register we=0 at the next edge when no buffer is full, with wR/wD holding their last values.
REQ-024 SHALL, at the same edge, clear full_X for the granted buffer unless a new transfer on X refills it in that cycle (refill wins; full_X stays set with new contents).
REQ-025 SHALL sustain one write per cycle per requester when uncontended, and one write per cycle total under contention.
REQ-026 SHALL let simultaneous A and B transfers to the same index both complete, written in grant order, so the later grant's data persists.
REQ-027 SHALL drive busy = full_A or full_B.

Reset
REQ-028 SHALL, while rst is high, asynchronously force full_A=full_B=0, we=0, wR=0, wD=0, and pointer set so that A wins the first contention.
REQ-029 SHALL, while rst is high, drive a_ready=b_ready=1 and busy=0; in-flight buffered writes are discarded, never emitted.
REQ-030 SHALL accept transfers from the first rising edge after rst deasserts.

Verification
REQ-031 SHALL cover a single write: A sends wr=5, wd=0x12345678 for one cycle -> next cycle full_A=1 and busy=1; the cycle after, we=1, wR=5, wD=0x12345678; then we=0.
REQ-032 SHALL cover contention with FAIR=1: A (wr=1, 0xA) and B (wr=2, 0xB) held valid for 4 cycles -> we sequence A,B,A,B, one write per cycle, no bubbles.
REQ-033 SHALL cover contention with FAIR=0 under the same stimulus -> A is granted every cycle, b_ready stays 0 while A keeps refilling, and B is written only after a_valid drops.
REQ-034 SHALL cover an x0 drop: A sends wr=0, wd=0xFFFFFFFF -> a_ready=1, busy stays 0, we never asserts.
REQ-035 SHALL cover a same-index race: A (wr=7, 0x1) and B (wr=7, 0x2) in the same cycle after reset -> we pulses twice, writing 0x1 first and then 0x2.
REQ-036 SHALL cover reset mid-operation: both buffers full, rst pulsed asynchronously between edges -> we=0, busy=0 and ready=1 immediately, and no pending write appears after release.
